// File: rtl/cosim_commit_queue.sv
// rtl/cosim_commit_queue.sv - retirement record queue replaying commits and traps one per cycle to the co-sim checker
// Multi-lane push with lane compaction, single pop into registered outputs, sticky overflow on rejected push cycles.
module cosim_commit_queue #(
  parameter int COMMIT_WIDTH = 2,
  parameter int XLEN         = 64,
  parameter int INST_BITS    = 32,
  parameter int DEPTH        = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [COMMIT_WIDTH-1:0]       valid,
  input  logic [XLEN*COMMIT_WIDTH-1:0]  pc,
  input  logic [INST_BITS*COMMIT_WIDTH-1:0] inst,
  input  logic [XLEN*COMMIT_WIDTH-1:0]  wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0]  mstatus,
  input  logic [COMMIT_WIDTH-1:0]       check,
  input  logic                          int_xcpt,
  input  logic [XLEN-1:0]               cause,
  input  logic                          drain_en,
  output logic                          out_valid,
  output logic [XLEN-1:0]               out_pc,
  output logic [INST_BITS-1:0]          out_inst,
  output logic [XLEN-1:0]               out_wdata,
  output logic [XLEN-1:0]               out_mstatus,
  output logic                          out_check,
  output logic                          out_int_xcpt,
  output logic [XLEN-1:0]               out_cause,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic                 mem_trap    [DEPTH];
  logic [XLEN-1:0]      mem_pc      [DEPTH];
  logic [INST_BITS-1:0] mem_inst    [DEPTH];
  logic [XLEN-1:0]      mem_wdata   [DEPTH];
  logic [XLEN-1:0]      mem_mstatus [DEPTH];
  logic                 mem_check   [DEPTH];
  logic [XLEN-1:0]      mem_cause   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] lane_idx [COMMIT_WIDTH];
  logic [PW-1:0] trap_idx;
  logic [2:0]    n_commit;
  logic [2:0]    pushes;
  logic [SW-1:0] next_fill;
  logic          pop;
  logic          accept;

  // Each valid lane lands after all older valid lanes; the trap goes after every commit.
  always_comb begin
    n_commit = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_idx[i] = wr_ptr + PW'(n_commit);
      n_commit    = n_commit + {2'b00, valid[i]};
    end
    trap_idx  = wr_ptr + PW'(n_commit);
    pushes    = n_commit + {2'b00, int_xcpt};
    pop       = drain_en && (count != '0);
    next_fill = SW'(count) - SW'(pop) + SW'(pushes);
    accept    = (next_fill <= SW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (valid[i]) begin
          mem_trap[lane_idx[i]]    <= 1'b0;
          mem_pc[lane_idx[i]]      <= pc[i*XLEN +: XLEN];
          mem_inst[lane_idx[i]]    <= inst[i*INST_BITS +: INST_BITS];
          mem_wdata[lane_idx[i]]   <= wdata[i*XLEN +: XLEN];
          mem_mstatus[lane_idx[i]] <= mstatus[i*XLEN +: XLEN];
          mem_check[lane_idx[i]]   <= check[i];
          mem_cause[lane_idx[i]]   <= '0;
        end
      end
      if (int_xcpt) begin
        mem_trap[trap_idx]    <= 1'b1;
        mem_pc[trap_idx]      <= '0;
        mem_inst[trap_idx]    <= '0;
        mem_wdata[trap_idx]   <= '0;
        mem_mstatus[trap_idx] <= '0;
        mem_check[trap_idx]   <= 1'b0;
        mem_cause[trap_idx]   <= cause;
      end
    end
  end

  // The pop is decided on pre-edge occupancy, so freshly pushed entries never bypass the queue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      out_valid    <= 1'b0;
      out_int_xcpt <= 1'b0;
      out_pc       <= '0;
      out_inst     <= '0;
      out_wdata    <= '0;
      out_mstatus  <= '0;
      out_check    <= 1'b0;
      out_cause    <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(pushes);
        count  <= next_fill[CW-1:0];
      end else begin
        count  <= count - CW'(pop);
      end
      overflow     <= overflow | ~accept;
      out_valid    <= pop && !mem_trap[rd_ptr];
      out_int_xcpt <= pop && mem_trap[rd_ptr];
      if (pop) begin
        rd_ptr      <= rd_ptr + PW'(1);
        out_pc      <= mem_pc[rd_ptr];
        out_inst    <= mem_inst[rd_ptr];
        out_wdata   <= mem_wdata[rd_ptr];
        out_mstatus <= mem_mstatus[rd_ptr];
        out_check   <= mem_check[rd_ptr];
        out_cause   <= mem_cause[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_cosim_commit_queue.sv
// tb/tb_cosim_commit_queue.sv - randomized and directed bench for cosim_commit_queue against a record-queue model
module tb_cosim_commit_queue;
  localparam int CWD = 2;
  localparam int XL  = 64;
  localparam int IB  = 32;
  localparam int D   = 8;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [CWD-1:0]     valid;
  logic [XL*CWD-1:0]  pc;
  logic [IB*CWD-1:0]  inst;
  logic [XL*CWD-1:0]  wdata;
  logic [XL*CWD-1:0]  mstatus;
  logic [CWD-1:0]     check;
  logic               int_xcpt;
  logic [XL-1:0]      cause;
  logic               drain_en;
  logic               out_valid;
  logic [XL-1:0]      out_pc;
  logic [IB-1:0]      out_inst;
  logic [XL-1:0]      out_wdata;
  logic [XL-1:0]      out_mstatus;
  logic               out_check;
  logic               out_int_xcpt;
  logic [XL-1:0]      out_cause;
  logic [$clog2(D):0] count;
  logic               overflow;

  cosim_commit_queue #(.COMMIT_WIDTH(CWD), .XLEN(XL), .INST_BITS(IB), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .valid(valid), .pc(pc), .inst(inst), .wdata(wdata),
    .mstatus(mstatus), .check(check), .int_xcpt(int_xcpt), .cause(cause), .drain_en(drain_en),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_wdata(out_wdata),
    .out_mstatus(out_mstatus), .out_check(out_check), .out_int_xcpt(out_int_xcpt),
    .out_cause(out_cause), .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          trap;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] wdata;
    logic [63:0] mstatus;
    logic        chk;
    logic [63:0] cause;
  } rec_t;

  rec_t q[$];
  rec_t last;
  int   last_kind;
  bit   exp_ovf;
  int   n_cmp;
  int   n_bad;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rnd_inputs();
    for (int i = 0; i < CWD; i++) begin
      pc[i*XL +: XL]      = {$urandom, $urandom};
      inst[i*IB +: IB]    = $urandom;
      wdata[i*XL +: XL]   = {$urandom, $urandom};
      mstatus[i*XL +: XL] = {$urandom, $urandom};
    end
    check = CWD'($urandom);
    cause = {$urandom, $urandom};
  endtask

  // Model one edge: pop from the head first, then accept the whole cycle's records or none of them.
  task automatic cycle();
    rec_t r;
    bit   ev, et;
    int   n;
    @(posedge clock);
    ev = 0;
    et = 0;
    if (drain_en && q.size() > 0) begin
      r = q.pop_front();
      last = r;
      last_kind = r.trap ? 2 : 1;
      ev = !r.trap;
      et = r.trap;
    end
    n = $countones(valid) + int'(int_xcpt);
    if (q.size() + n > D) begin
      exp_ovf = 1;
    end else begin
      for (int i = 0; i < CWD; i++) begin
        if (valid[i]) begin
          r.trap = 0; r.pc = pc[i*XL +: XL]; r.inst = inst[i*IB +: IB];
          r.wdata = wdata[i*XL +: XL]; r.mstatus = mstatus[i*XL +: XL];
          r.chk = check[i]; r.cause = '0;
          q.push_back(r);
        end
      end
      if (int_xcpt) begin
        r.trap = 1; r.pc = '0; r.inst = '0; r.wdata = '0; r.mstatus = '0; r.chk = 0; r.cause = cause;
        q.push_back(r);
      end
    end
    #1;
    check_eq("out_valid", 64'(out_valid), 64'(ev));
    check_eq("out_int_xcpt", 64'(out_int_xcpt), 64'(et));
    check_eq("count", 64'(count), 64'(q.size()));
    check_eq("overflow", 64'(overflow), 64'(exp_ovf));
    if (last_kind == 1) begin
      check_eq("out_pc", out_pc, last.pc);
      check_eq("out_inst", 64'(out_inst), 64'(last.inst));
      check_eq("out_wdata", out_wdata, last.wdata);
      check_eq("out_mstatus", out_mstatus, last.mstatus);
      check_eq("out_check", 64'(out_check), 64'(last.chk));
    end else if (last_kind == 2) begin
      check_eq("out_cause", out_cause, last.cause);
    end
  endtask

  task automatic push(input logic [CWD-1:0] v, input logic x, input logic [63:0] p0, input logic [63:0] p1);
    rnd_inputs();
    valid = v;
    int_xcpt = x;
    pc[0 +: XL] = p0;
    pc[XL +: XL] = p1;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rnd_inputs();
      valid = '0;
      int_xcpt = 1'b0;
      cycle();
    end
  endtask

  // Asserted between edges so the asynchronous clear is observable before any clock.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_int_xcpt", 64'(out_int_xcpt), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_out_pc", out_pc, 64'd0);
    check_eq("rst_out_cause", out_cause, 64'd0);
    q.delete();
    exp_ovf = 0;
    last_kind = 0;
    valid = '0;
    int_xcpt = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_kind = 0;
    exp_ovf = 0;
    valid = '0;
    int_xcpt = 1'b0;
    drain_en = 1'b0;
    rnd_inputs();
    apply_reset();

    // single-lane ordering
    drain_en = 1'b1;
    push(2'b01, 1'b0, 64'h8000_0000, 64'h0);
    push(2'b01, 1'b0, 64'h8000_0004, 64'h0);
    idle(4);

    // dual-lane burst
    for (int k = 0; k < 3; k++) push(2'b11, 1'b0, 64'h100, 64'h104);
    idle(8);

    // trap ordering
    push(2'b01, 1'b1, 64'h200, 64'h0);
    cause = 64'h8000_0000_0000_0007;
    idle(4);

    // overflow with no drain, then release
    apply_reset();
    drain_en = 1'b0;
    for (int k = 0; k < 4; k++) push(2'b11, 1'b0, 64'h1000 + 64'(k*8), 64'h1004 + 64'(k*8));
    push(2'b01, 1'b0, 64'hdead, 64'h0);
    check_eq("ovf_sticky", 64'(overflow), 64'd1);
    check_eq("ovf_count", 64'(count), 64'd8);
    drain_en = 1'b1;
    idle(10);

    // wrap straddle: move pointers to 7, then lane0, lane1, trap across the wrap
    apply_reset();
    drain_en = 1'b1;
    for (int k = 0; k < 7; k++) push(2'b01, 1'b0, 64'h300 + 64'(k*4), 64'h0);
    idle(3);
    push(2'b11, 1'b1, 64'h400, 64'h404);
    idle(5);

    // reset mid-drain at count 5
    drain_en = 1'b0;
    push(2'b11, 1'b0, 64'h500, 64'h504);
    push(2'b11, 1'b0, 64'h508, 64'h50c);
    push(2'b01, 1'b0, 64'h510, 64'h0);
    check_eq("pre_reset_count", 64'(count), 64'd5);
    drain_en = 1'b1;
    apply_reset();
    idle(2);

    // randomized traffic with periodic resets to clear the sticky flag
    for (int seg = 0; seg < 8; seg++) begin
      apply_reset();
      for (int k = 0; k < 300; k++) begin
        rnd_inputs();
        valid = CWD'($urandom);
        int_xcpt = ($urandom_range(0, 7) == 0);
        drain_en = (seg % 2 == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0);
        cycle();
      end
      drain_en = 1'b1;
      idle(12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
